// File: rtl/regfile_write_arbiter_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : regfile_write_arbiter_pkg
//  Description : Shared register-file constants for the writeback arbiter:
//                address/data widths, register count and source indices.
//  Ports       : none (package)
//  Revision    : 1.0 - initial release
// ============================================================================
package regfile_write_arbiter_pkg;

  localparam int REG_ADDR_W = 4;
  localparam int NUM_REGS   = 16;
  localparam int DATA_W     = 32;
  localparam int NUM_WB_SRC = 2;

  // Writeback source indices
  localparam int SRC_ALU    = 0;
  localparam int SRC_MEM    = 1;

endpackage : regfile_write_arbiter_pkg
`default_nettype wire

// File: rtl/regfile_write_arbiter_if.sv
`default_nettype none
// ============================================================================
//  Module      : regfile_write_arbiter_if
//  Description : Bus bundle between the writeback sources and the register
//                file write arbiter.
//  Ports       : master - writeback side (drives requests and stall)
//                slave  - arbiter side (drives ready, decoder, data, busy)
//  Revision    : 1.0 - initial release
// ============================================================================
interface regfile_write_arbiter_if
  import regfile_write_arbiter_pkg::*;
#(
  parameter int NUM_REQ = NUM_WB_SRC,
  parameter int ADDR_W  = REG_ADDR_W,
  parameter int DATA_W  = regfile_write_arbiter_pkg::DATA_W
);

  logic [NUM_REQ-1:0]        req_valid;
  logic [NUM_REQ-1:0]        req_ready;
  logic [NUM_REQ*ADDR_W-1:0] req_addr;
  logic [NUM_REQ*DATA_W-1:0] req_data;
  logic                      stall;
  logic [ADDR_W-1:0]         dec_in;
  logic                      dec_load_enable;
  logic [DATA_W-1:0]         rf_data;
  logic                      busy;

  modport master (
    output req_valid, req_addr, req_data, stall,
    input  req_ready, dec_in, dec_load_enable, rf_data, busy
  );

  modport slave (
    input  req_valid, req_addr, req_data, stall,
    output req_ready, dec_in, dec_load_enable, rf_data, busy
  );

endinterface : regfile_write_arbiter_if
`default_nettype wire

// File: rtl/binary_decoder.sv
`default_nettype none
// ============================================================================
//  Module      : binary_decoder
//  Description : IN_W-to-2^IN_W one-hot decoder with enable; produces the
//                per-register load strobes of the register file.
//  Ports       : i_sel    - binary register select
//                i_en     - enable; all outputs low when 0
//                o_onehot - one-hot load strobe
//  Revision    : 1.0 - initial release
// ============================================================================
module binary_decoder #(
  parameter int IN_W  = 4,
  parameter int OUT_W = 1 << IN_W
) (
  input  wire logic [IN_W-1:0]  i_sel,
  input  wire logic             i_en,
  output logic      [OUT_W-1:0] o_onehot
);

  localparam logic [OUT_W-1:0] C_ONE = OUT_W'(1);

  assign o_onehot = i_en ? (C_ONE << i_sel) : '0;

endmodule : binary_decoder
`default_nettype wire

// File: rtl/regfile_write_arbiter_rr_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : rr_arbiter
//  Description : Combinational round-robin pick: first candidate at or after
//                the pointer, wrapping. The pointer register lives in the
//                parent.
//  Ports       : i_candidates - request vector
//                i_rr_ptr     - highest-priority index this cycle
//                o_grant      - one-hot grant
//                o_grant_idx  - binary index of the grant
//                o_any        - at least one candidate present
//  Revision    : 1.0 - initial release
// ============================================================================
module rr_arbiter
  import regfile_write_arbiter_pkg::*;
#(
  parameter int NUM_REQ = NUM_WB_SRC,
  parameter int PTR_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  wire logic [NUM_REQ-1:0] i_candidates,
  input  wire logic [PTR_W-1:0]   i_rr_ptr,
  output logic      [NUM_REQ-1:0] o_grant,
  output logic      [PTR_W-1:0]   o_grant_idx,
  output logic                    o_any
);

  always_comb begin
    int w_j;
    o_grant     = '0;
    o_grant_idx = '0;
    o_any       = 1'b0;
    w_j         = 0;
    // Scan NUM_REQ positions starting at the pointer; first hit wins.
    for (int k = 0; k < NUM_REQ; k++) begin
      w_j = (int'(i_rr_ptr) + k) % NUM_REQ;
      if (!o_any && i_candidates[w_j]) begin
        o_any          = 1'b1;
        o_grant[w_j]   = 1'b1;
        o_grant_idx    = PTR_W'(w_j);
      end
    end
  end

endmodule : rr_arbiter
`default_nettype wire

// File: rtl/regfile_write_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : regfile_write_arbiter
//  Description : Shares the register file's single write port between the
//                writeback sources (0 = ALU, 1 = memory load). One holding
//                slot per source, round-robin selection, registered decoder
//                select/enable and write data. At most one write per cycle.
//  Ports       : clk    - rising-edge clock
//                reset  - asynchronous active-high reset
//                bus    - slave side of regfile_write_arbiter_if
//                         (req_valid/ready/addr/data, stall, dec_in,
//                          dec_load_enable, rf_data, busy)
//  Revision    : 1.0 - initial release
// ============================================================================
module regfile_write_arbiter
  import regfile_write_arbiter_pkg::*;
#(
  parameter int NUM_REQ = NUM_WB_SRC,
  parameter int ADDR_W  = REG_ADDR_W,
  parameter int DATA_W  = regfile_write_arbiter_pkg::DATA_W
) (
  input wire logic               clk,
  input wire logic               reset,
  regfile_write_arbiter_if.slave bus
);

  localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  logic [NUM_REQ-1:0] r_held_v;
  logic [ADDR_W-1:0]  r_held_addr [NUM_REQ];
  logic [DATA_W-1:0]  r_held_data [NUM_REQ];
  logic [PTR_W-1:0]   r_rr_ptr;
  logic [ADDR_W-1:0]  r_dec_in;
  logic [DATA_W-1:0]  r_rf_data;
  logic               r_dec_en;

  logic [NUM_REQ-1:0] w_grant;
  logic [PTR_W-1:0]   w_grant_idx;
  logic               w_any;
  logic               w_fire;
  logic [NUM_REQ-1:0] w_accept;
  logic [PTR_W-1:0]   w_next_ptr;

  rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .PTR_W   (PTR_W)
  ) u_rr_arbiter (
    .i_candidates (r_held_v),
    .i_rr_ptr     (r_rr_ptr),
    .o_grant      (w_grant),
    .o_grant_idx  (w_grant_idx),
    .o_any        (w_any)
  );

  // Ready depends only on slot occupancy, so a slot being drained this
  // cycle cannot be refilled until the next one.
  assign w_accept   = bus.req_valid & ~r_held_v;
  assign w_fire     = w_any && !bus.stall;
  assign w_next_ptr = (w_grant_idx == PTR_W'(NUM_REQ - 1)) ? '0
                                                           : w_grant_idx + PTR_W'(1);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_held_v  <= '0;
      for (int i = 0; i < NUM_REQ; i++) begin
        r_held_addr[i] <= '0;
        r_held_data[i] <= '0;
      end
      r_rr_ptr  <= '0;
      r_dec_in  <= '0;
      r_rf_data <= '0;
      r_dec_en  <= 1'b0;
    end else begin
      // Accept and drain are mutually exclusive per slot (empty vs full).
      for (int i = 0; i < NUM_REQ; i++) begin
        if (w_accept[i]) begin
          r_held_v[i]    <= 1'b1;
          r_held_addr[i] <= bus.req_addr[i*ADDR_W +: ADDR_W];
          r_held_data[i] <= bus.req_data[i*DATA_W +: DATA_W];
        end else if (w_fire && w_grant[i]) begin
          r_held_v[i]    <= 1'b0;
        end
      end

      if (w_fire) begin
        r_dec_in  <= r_held_addr[w_grant_idx];
        r_rf_data <= r_held_data[w_grant_idx];
        r_dec_en  <= 1'b1;
        r_rr_ptr  <= w_next_ptr;
      end else begin
        // dec_in/rf_data keep their last values; only the enable drops.
        r_dec_en  <= 1'b0;
      end
    end
  end

  assign bus.req_ready       = ~r_held_v;
  assign bus.dec_in          = r_dec_in;
  assign bus.dec_load_enable = r_dec_en;
  assign bus.rf_data         = r_rf_data;
  assign bus.busy            = (|r_held_v) | r_dec_en;

endmodule : regfile_write_arbiter
`default_nettype wire

// File: tb/tb_regfile_write_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_regfile_write_arbiter
//  Description : Scoreboard bench for regfile_write_arbiter with a decoder
//                on the write-port outputs.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_regfile_write_arbiter;
  import regfile_write_arbiter_pkg::*;

  localparam int NR = 2;
  localparam int AW = 4;
  localparam int DW = 32;

  logic clk   = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  regfile_write_arbiter_if #(.NUM_REQ(NR), .ADDR_W(AW), .DATA_W(DW)) bus ();

  regfile_write_arbiter #(.NUM_REQ(NR), .ADDR_W(AW), .DATA_W(DW)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  logic [15:0] onehot;
  binary_decoder #(.IN_W(AW)) u_dec (
    .i_sel    (bus.dec_in),
    .i_en     (bus.dec_load_enable),
    .o_onehot (onehot)
  );

  typedef struct {
    int          cyc;
    logic [3:0]  addr;
    logic [31:0] data;
  } exp_t;

  exp_t sb_q[$];

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;
  bit done     = 1'b0;

  // Reference model: pending request per source, priority pointer, and the
  // values the write port is showing.
  bit          m_v    [NR];
  logic [3:0]  m_addr [NR];
  logic [31:0] m_data [NR];
  int          m_ptr;
  bit          m_en;
  logic [3:0]  m_hold_addr;
  logic [31:0] m_hold_data;

  task automatic check(string name, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic model_clear();
    for (int i = 0; i < NR; i++) begin
      m_v[i] = 1'b0; m_addr[i] = '0; m_data[i] = '0;
    end
    m_ptr = 0; m_en = 1'b0; m_hold_addr = '0; m_hold_data = '0;
    sb_q.delete();
  endtask

  // Called on every rising edge with the inputs that were presented there.
  task automatic model_edge();
    bit pre_v [NR];
    int w;
    cyc++;
    if (reset) begin
      model_clear();
      return;
    end
    for (int i = 0; i < NR; i++) pre_v[i] = m_v[i];
    m_en = 1'b0;
    w = -1;
    if (!bus.stall) begin
      for (int k = 0; k < NR; k++)
        if (w < 0 && pre_v[(m_ptr + k) % NR]) w = (m_ptr + k) % NR;
    end
    if (w >= 0) begin
      sb_q.push_back('{cyc: cyc, addr: m_addr[w], data: m_data[w]});
      m_hold_addr = m_addr[w];
      m_hold_data = m_data[w];
      m_en        = 1'b1;
      m_v[w]      = 1'b0;
      m_ptr       = (w + 1) % NR;
    end
    for (int i = 0; i < NR; i++) begin
      if (!pre_v[i] && bus.req_valid[i]) begin
        m_v[i]    = 1'b1;
        m_addr[i] = bus.req_addr[i*AW +: AW];
        m_data[i] = bus.req_data[i*DW +: DW];
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    #2;
  endtask

  task automatic drive(logic [1:0] v, logic [3:0] a0, logic [31:0] d0,
                       logic [3:0] a1, logic [31:0] d1, logic st);
    bus.req_valid = v;
    bus.req_addr  = {a1, a0};
    bus.req_data  = {d1, d0};
    bus.stall     = st;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    model_clear();
    tick();
    tick();
    reset = 1'b0;
  endtask

  // Monitor: compares the write port against the scoreboard every cycle.
  initial begin
    logic [1:0] exp_ready;
    bit         exp_en;
    exp_t       e;
    while (!done) begin
      @(negedge clk);
      if (done) break;
      while (sb_q.size() > 0 && sb_q[0].cyc < cyc) begin
        e = sb_q.pop_front();
        check("missed_write", 64'(cyc), 64'(e.cyc));
      end
      exp_en = (sb_q.size() > 0 && sb_q[0].cyc == cyc);
      check("dec_load_enable", 64'(bus.dec_load_enable), 64'(exp_en));
      if (exp_en) begin
        e = sb_q.pop_front();
        check("dec_in", 64'(bus.dec_in), 64'(e.addr));
        check("rf_data", 64'(bus.rf_data), 64'(e.data));
        check("decoder_out", 64'(onehot), 64'(16'h1 << e.addr));
      end else begin
        check("dec_in_hold", 64'(bus.dec_in), 64'(m_hold_addr));
        check("rf_data_hold", 64'(bus.rf_data), 64'(m_hold_data));
        check("decoder_idle", 64'(onehot), 64'h0);
      end
      for (int i = 0; i < NR; i++) exp_ready[i] = !m_v[i];
      check("req_ready", 64'(bus.req_ready), 64'(exp_ready));
      check("busy", 64'(bus.busy), 64'(m_v[0] | m_v[1] | m_en));
    end
  end

  initial begin
    drive(2'b00, 4'h0, 32'h0, 4'h0, 32'h0, 1'b0);
    model_clear();
    tick();
    tick();
    reset = 1'b0;

    // Single write from the ALU
    drive(2'b01, 4'h5, 32'hA5A5_0001, 4'h0, 32'h0, 1'b0);
    tick();
    drive(2'b00, 4'h0, 32'h0, 4'h0, 32'h0, 1'b0);
    tick();
    check("single_dec_in", 64'(bus.dec_in), 64'h5);
    check("single_onehot", 64'(onehot), 64'h0020);
    check("single_rf_data", 64'(bus.rf_data), 64'hA5A5_0001);
    tick();
    check("single_en_drop", 64'(bus.dec_load_enable), 64'h0);
    tick();

    // Simultaneous requests after reset
    do_reset();
    drive(2'b11, 4'h2, 32'h1111_0002, 4'h9, 32'h2222_0009, 1'b0);
    tick();
    drive(2'b00, 4'h0, 32'h0, 4'h0, 32'h0, 1'b0);
    tick();
    check("simul_first", 64'(onehot), 64'h0004);
    tick();
    check("simul_second", 64'(onehot), 64'h0200);
    tick();
    check("simul_done", 64'(bus.dec_load_enable), 64'h0);

    // Same address from both sources
    do_reset();
    drive(2'b11, 4'h7, 32'h1, 4'h7, 32'h2, 1'b0);
    tick();
    drive(2'b00, 4'h0, 32'h0, 4'h0, 32'h0, 1'b0);
    tick();
    tick();
    check("same_final_data", 64'(bus.rf_data), 64'h2);
    check("same_busy_n2", 64'(bus.busy), 64'h1);
    tick();
    check("same_busy_n3", 64'(bus.busy), 64'h0);

    // Fairness: both continuously valid; distinct addresses identify source
    for (int c = 0; c < 10; c++) begin
      drive(2'b11, 4'h3, $urandom, 4'hC, $urandom, 1'b0);
      tick();
    end

    // Stall with both slots full, then release
    drive(2'b11, 4'h4, 32'hDEAD_0004, 4'hB, 32'hBEEF_000B, 1'b1);
    for (int c = 0; c < 4; c++) tick();
    check("stall_ready", 64'(bus.req_ready), 64'h0);
    drive(2'b00, 4'h0, 32'h0, 4'h0, 32'h0, 1'b0);
    for (int c = 0; c < 4; c++) tick();

    // Reset asserted while a write is on the port
    drive(2'b11, 4'h6, 32'h6666_0006, 4'hE, 32'hEEEE_000E, 1'b0);
    tick();
    drive(2'b00, 4'h0, 32'h0, 4'h0, 32'h0, 1'b0);
    tick();
    check("pre_reset_en", 64'(bus.dec_load_enable), 64'h1);
    reset = 1'b1;
    model_clear();
    #1;
    check("rst_en", 64'(bus.dec_load_enable), 64'h0);
    check("rst_onehot", 64'(onehot), 64'h0);
    check("rst_ready", 64'(bus.req_ready), 64'h3);
    check("rst_busy", 64'(bus.busy), 64'h0);
    check("rst_rf_data", 64'(bus.rf_data), 64'h0);
    tick();
    reset = 1'b0;

    // Randomized traffic with random stalls
    for (int c = 0; c < 400; c++) begin
      drive(2'($urandom), 4'($urandom), $urandom, 4'($urandom), $urandom,
            ($urandom_range(0, 3) == 0));
      tick();
    end

    // Drain
    drive(2'b00, 4'h0, 32'h0, 4'h0, 32'h0, 1'b0);
    for (int c = 0; c < 5; c++) tick();
    @(negedge clk);
    #1;
    check("scoreboard_empty", 64'(sb_q.size()), 64'h0);
    done = 1'b1;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule : tb_regfile_write_arbiter
`default_nettype wire
